// File: rtl/lfsr_pkg.sv
// Shared constants and helpers for the LFSR stream generator.
// Provides form selectors and per-width default tap masks and seeds.
package lfsr_pkg;

    // Feedback form selectors for the GALOIS parameter
    localparam int unsigned LFSR_FIB = 0;
    localparam int unsigned LFSR_GAL = 1;

    // Legal width range of the generator
    localparam int unsigned LFSR_MIN_WIDTH = 3;
    localparam int unsigned LFSR_MAX_WIDTH = 32;

    // Maximal-length Fibonacci tap masks; bit i set means state[i] feeds the XOR.
    //  8: x^8+x^6+x^5+x^4+1
    // 16: x^16+x^14+x^13+x^11+1
    // 24: x^24+x^23+x^22+x^17+1
    // 32: x^32+x^22+x^2+x^1+1
    // Other widths fall back to the two top bits, which is not maximal in general.
    function automatic logic [31:0] default_taps(input int unsigned width);
        logic [31:0] taps;
        case (width)
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            24:      taps = 32'h00E1_0000;
            32:      taps = 32'h8020_0003;
            default: taps = (32'd1 << (width - 1)) | (32'd1 << (width - 2));
        endcase
        return taps;
    endfunction

    // All-ones seed of the given width; never zero, so it is a legal start state
    function automatic logic [31:0] default_seed(input int unsigned width);
        logic [31:0] seed;
        if (width >= 32) begin
            seed = '1;
        end else begin
            seed = (32'd1 << width) - 32'd1;
        end
        return seed;
    endfunction

endpackage

// File: rtl/lfsr_stream_gen_if.sv
// Output stream bundle of the LFSR generator: value, valid/ready handshake
// and the period/lock-up status that travels with it.
interface lfsr_stream_gen_if #(
    parameter int unsigned WIDTH = 16
);

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] lfsr_q;
    logic             wrap;
    logic             lockup;
    logic [WIDTH-1:0] step_cnt;

    // Producer side: the generator
    modport master (
        output out_valid,
        output lfsr_q,
        output wrap,
        output lockup,
        output step_cnt,
        input  out_ready
    );

    // Consumer side
    modport slave (
        input  out_valid,
        input  lfsr_q,
        input  wrap,
        input  lockup,
        input  step_cnt,
        output out_ready
    );

endinterface

// File: rtl/lfsr_next.sv
// Combinational next-state function of the LFSR, Fibonacci or Galois form.
// The Galois form multiplies the state by x modulo the feedback polynomial
// whose low coefficients are TAPS shifted up by one with the constant term set.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(default_taps(WIDTH)),
    parameter int unsigned      GALOIS = LFSR_FIB
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    if (GALOIS == LFSR_GAL) begin : g_galois
        localparam logic [WIDTH-1:0] GPOLY = {TAPS[WIDTH-2:0], 1'b1};

        // Shift left; fold the bit leaving the top back in through the polynomial
        always_comb begin
            nxt = {cur[WIDTH-2:0], 1'b0};
            if (cur[WIDTH-1]) begin
                nxt = nxt ^ GPOLY;
            end
        end
    end else begin : g_fibonacci
        // Shift left; parity of the tapped bits enters at bit 0
        always_comb begin
            nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};
        end
    end

endmodule

// File: rtl/lfsr_stream_gen.sv
// Parametrised LFSR pseudo-random stream source with valid/ready output,
// run-time seed load, all-zero lock-up recovery and full-period detection.
// The LED output mirrors the current state when gated on.
module lfsr_stream_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH  = 16,
    parameter logic [WIDTH-1:0] TAPS   = WIDTH'(default_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED   = WIDTH'(default_seed(WIDTH)),
    parameter int unsigned      GALOIS = LFSR_FIB
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic               load,
    input  logic [WIDTH-1:0]   seed_in,
    input  logic               LEDenable,
    output logic [WIDTH-1:0]   led,
    lfsr_stream_gen_if.master  stream
);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] next_state;
    logic             accept;
    logic             step;

    lfsr_next #(
        .WIDTH  (WIDTH),
        .TAPS   (TAPS),
        .GALOIS (GALOIS)
    ) u_next (
        .cur (state_q),
        .nxt (next_state)
    );

    // A new value may replace the current one only once it has been consumed
    assign accept = ~valid_q | stream.out_ready;
    assign step   = enable & accept;

    // Next-state: load beats lock-up recovery beats stepping beats holding
    always_comb begin
        state_d  = state_q;
        start_d  = start_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q & ~stream.out_ready;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;

        if (load) begin
            state_d = seed_in;
            start_d = seed_in;
            cnt_d   = '0;
            valid_d = 1'b1;
        end else if (state_q == '0) begin
            // All-zero is a fixed point of the XOR feedback; restart from SEED
            state_d  = SEED;
            start_d  = SEED;
            cnt_d    = '0;
            lockup_d = 1'b1;
            valid_d  = 1'b0;
        end else if (step) begin
            state_d = next_state;
            valid_d = 1'b1;
            if (next_state == start_q) begin
                wrap_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
    end

    // State, handshake and flag registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= SEED;
            start_q  <= SEED;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            start_q  <= start_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            wrap_q   <= wrap_d;
            lockup_q <= lockup_d;
        end
    end

    // LED gate is purely combinational from the visible state
    always_comb begin
        led = LEDenable ? state_q : '0;
    end

    assign stream.lfsr_q    = state_q;
    assign stream.out_valid = valid_q;
    assign stream.wrap      = wrap_q;
    assign stream.lockup    = lockup_q;
    assign stream.step_cnt  = cnt_q;

endmodule
